// File: rtl/ram_string_transmitter_if.sv
// Command, RAM-write and status bundle for ram_string_transmitter.
// Latency: none (wires only).
// Backpressure: none. busy tells the controller when a new start is accepted.
// Ports: master = system control side (drives writes/commands, sees status),
//        slave  = transmitter side. parity_odd exists only with TX_PARITY_EN.
interface ram_string_transmitter_if #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 start;
    logic                 abort;
    logic                 repeat_mode;
    logic [ADDR_BITS:0]   msg_length;
`ifdef TX_PARITY_EN
    logic                 parity_odd;
`endif
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] char_index;

    modport master (
`ifdef TX_PARITY_EN
        output parity_odd,
`endif
        output wr_en, wr_addr, wr_data, start, abort, repeat_mode, msg_length,
        input  tx, busy, done, char_index
    );

    modport slave (
`ifdef TX_PARITY_EN
        input  parity_odd,
`endif
        input  wr_en, wr_addr, wr_data, start, abort, repeat_mode, msg_length,
        output tx, busy, done, char_index
    );
endinterface

// File: rtl/ram_string_transmitter.sv
// Streams characters from an internal message RAM out of a UART TX line.
// Latency: tx falls 3 edges after start is sampled; 3 idle-high cycles between frames.
// Backpressure: start is accepted only in IDLE; writes are accepted at any time.
// Ports: clock (rising edge), reset (async, active low), bus (slave modport:
//        RAM write port, start/abort/repeat_mode/msg_length commands,
//        tx/busy/done/char_index status).
// Optional macro TX_PARITY_EN: adds a parity bit after the data bits and the
//        parity_odd input (0 = even, 1 = odd), sampled in LOAD.
module ram_string_transmitter #(
    parameter int CLK_FREQ  = 40000000,
    parameter int BAUD_RATE = 19200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int ADDR_BITS = 5,
    parameter int DEPTH     = 32
) (
    input  logic clock,
    input  logic reset,
    ram_string_transmitter_if.slave bus
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW         = $clog2(BIT_CYCLES);
`ifdef TX_PARITY_EN
    localparam int SHIFT_BITS = DATA_BITS + 1;
`else
    localparam int SHIFT_BITS = DATA_BITS;
`endif
    localparam logic [CW-1:0]      CNT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [3:0]         SHIFT_LAST = 4'(SHIFT_BITS - 1);
    localparam logic [3:0]         STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [ADDR_BITS:0] DEPTH_W    = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_W      = (ADDR_BITS+1)'(1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, GAP} state_t;

    state_t                state;
    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DATA_BITS-1:0]  rd_data;
    logic [SHIFT_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [3:0]            bit_cnt;
    logic                  abort_seen;
    logic                  tx_r;
    logic                  busy_r;
    logic                  done_r;
    logic [ADDR_BITS-1:0]  idx_r;
    logic [ADDR_BITS:0]    eff_len;
    logic [ADDR_BITS:0]    next_idx;

    assign bus.tx         = tx_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.char_index = idx_r;

    // Length is re-evaluated live, so a new msg_length lands at the next GAP decision.
    assign eff_len  = (bus.msg_length > DEPTH_W) ? DEPTH_W : bus.msg_length;
    assign next_idx = {1'b0, idx_r} + ONE_W;

    // Message RAM: no reset, read-first, out-of-range writes dropped.
    always_ff @(posedge clock) begin
        if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W))
            mem[bus.wr_addr] <= bus.wr_data;
        rd_data <= mem[idx_r];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            idx_r      <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            abort_seen <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // tx is the registered image of the previous state: this one-cycle lag
            // is what places the start bit on the third edge after start.
            case (state)
                START:   tx_r <= 1'b0;
                DATA:    tx_r <= shreg[0];
                default: tx_r <= 1'b1;
            endcase

            if (state != IDLE && bus.abort)
                abort_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start && eff_len != '0) begin
                        state      <= FETCH;
                        busy_r     <= 1'b1;
                        idx_r      <= '0;
                        abort_seen <= 1'b0;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
`ifdef TX_PARITY_EN
                    shreg <= {(^rd_data) ^ bus.parity_odd, rd_data};
`else
                    shreg <= rd_data;
`endif
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= START;
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    // Counter reloads at each bit boundary: no accumulated drift.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[SHIFT_BITS-1:1]};
                        if (bit_cnt == SHIFT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (abort_seen || bus.abort) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (next_idx < eff_len) begin
                        idx_r      <= next_idx[ADDR_BITS-1:0];
                        abort_seen <= 1'b0;
                        state      <= FETCH;
                    end else begin
                        done_r <= 1'b1;
                        if (bus.repeat_mode) begin
                            idx_r      <= '0;
                            abort_seen <= 1'b0;
                            state      <= FETCH;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_string_transmitter.sv
module tb_ram_string_transmitter;
    localparam int AB    = 5;
    localparam int DEPTH = 32;
    localparam int BITC  = 10;
`ifdef TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PER  = FB * BITC + 3;
    localparam int MAXC = 16384;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ram_string_transmitter_if #(.ADDR_BITS(AB), .DATA_BITS(8)) bus();

    ram_string_transmitter #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
        .STOP_BITS(1), .ADDR_BITS(AB), .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Timeline model: expected outputs per cycle, laid out from frame arithmetic.
    logic          m_tx   [MAXC];
    logic          m_busy [MAXC];
    logic          m_done [MAXC];
    logic [AB-1:0] m_idx  [MAXC];
    logic [7:0]    mem_m  [DEPTH];
    logic          po_m;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fill_idle(input int from, input logic [AB-1:0] idx);
        for (int n = from; n < MAXC; n++) begin
            m_tx[n] = 1'b1; m_busy[n] = 1'b0; m_done[n] = 1'b0; m_idx[n] = idx;
        end
    endtask

    // Frame f of a run sampled at edge e0 occupies cycles e0+PER*f .. +PER-1:
    // three high cycles, then start, data LSB first, [parity], stop.
    task automatic plan(input int e0, input int nf, input int len, input bit rep, input bit aborted);
        int a;
        int base;
        int endc;
        logic [7:0] d;
        logic [FB-1:0] fr;
        logic [AB-1:0] la;
        la = '0;
        for (int f = 0; f < nf; f++) begin
            a = rep ? (f % len) : f;
            d = mem_m[a];
            fr = '1;
            fr[0] = 1'b0;
            for (int i = 0; i < 8; i++) fr[i+1] = d[i];
`ifdef TX_PARITY_EN
            fr[9] = (^d) ^ po_m;
`endif
            base = e0 + PER * f;
            for (int k = 0; k < PER; k++) begin
                m_busy[base+k] = 1'b1;
                m_done[base+k] = 1'b0;
                m_idx[base+k]  = a[AB-1:0];
                m_tx[base+k]   = (k < 3) ? 1'b1 : fr[(k-3)/BITC];
            end
            la = a[AB-1:0];
        end
        endc = e0 + PER * nf;
        fill_idle(endc, la);
        for (int f = 0; f < nf; f++) begin
            a = rep ? (f % len) : f;
            if (a == len - 1 && !(aborted && f == nf - 1))
                m_done[e0 + PER * (f + 1)] = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (cyc < MAXC) begin
            chk("tx",         bus.tx,         m_tx[cyc]);
            chk("busy",       bus.busy,       m_busy[cyc]);
            chk("done",       bus.done,       m_done[cyc]);
            chk("char_index", bus.char_index, m_idx[cyc]);
        end
    end

    always @(negedge clock) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a[AB-1:0]; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (a < DEPTH) mem_m[a] = d;
    endtask

    task automatic go(input int len, input bit rep, input int nf, input bit aborted, output int e0);
        bus.msg_length  = len[AB:0];
        bus.repeat_mode = rep;
        e0 = cyc + 1;
        if (nf > 0) plan(e0, nf, (len > DEPTH) ? DEPTH : len, rep, aborted);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Independent line receiver: finds the falling edge, samples mid-bit.
    task automatic rx_frame(output logic [7:0] d, output logic b9, output int fall);
        int w;
        w = 0; d = '0; b9 = 1'b1; fall = -1;
        while (bus.tx !== 1'b0 && w < 400) begin
            @(negedge clock);
            w++;
        end
        if (w >= 400) begin
            chk("rx_timeout", 32'd0, 32'd1);
            return;
        end
        fall = cyc;
        repeat (14) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            d[i] = bus.tx;
            repeat (10) @(negedge clock);
        end
        b9 = bus.tx;
    endtask

    initial begin
        int e0;
        int dc0;
        int fl [3];
        logic [7:0] rd [3];
        logic b9 [3];

        fill_idle(0, '0);
        po_m = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.repeat_mode = 1'b0; bus.msg_length = '0;
`ifdef TX_PARITY_EN
        bus.parity_odd = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_tx",   bus.tx, 32'd1);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_idx",  bus.char_index, 32'd0);
        reset = 1'b1;
        tick();

        // 1: single character
        wr(0, 8'h41);
        dc0 = done_cnt;
        go(1, 1'b0, 1, 1'b0, e0);
        rx_frame(rd[0], b9[0], fl[0]);
        chk("t1_latency", fl[0] - e0, 32'd3);
        chk("t1_data", rd[0], 32'h41);
`ifdef TX_PARITY_EN
        chk("t1_parity", b9[0], 32'd0);
`else
        chk("t1_stop", b9[0], 32'd1);
`endif
        wait_until(e0 + PER + 2);
        chk("t1_dones", done_cnt - dc0, 32'd1);
        chk("t1_busy", bus.busy, 32'd0);
        chk("t1_idx", bus.char_index, 32'd0);

        // 2: "HI!"
        wr(0, 8'h48); wr(1, 8'h49); wr(2, 8'h21);
        dc0 = done_cnt;
        go(3, 1'b0, 3, 1'b0, e0);
        for (int i = 0; i < 3; i++) rx_frame(rd[i], b9[i], fl[i]);
        chk("t2_c0", rd[0], 32'h48);
        chk("t2_c1", rd[1], 32'h49);
        chk("t2_c2", rd[2], 32'h21);
        chk("t2_gap01", fl[1] - fl[0] - FB * BITC, 32'd3);
        chk("t2_gap12", fl[2] - fl[1] - FB * BITC, 32'd3);
        wait_until(e0 + 3 * PER + 2);
        chk("t2_dones", done_cnt - dc0, 32'd1);

        // 3: repeat "AB", abort during the second 'A'
        wr(0, 8'h41); wr(1, 8'h42);
        dc0 = done_cnt;
        go(2, 1'b1, 3, 1'b1, e0);
        fork
            for (int i = 0; i < 3; i++) rx_frame(rd[i], b9[i], fl[i]);
            begin
                wait_until(e0 + 2 * PER + 40);
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
            end
        join
        chk("t3_c0", rd[0], 32'h41);
        chk("t3_c1", rd[1], 32'h42);
        chk("t3_c2", rd[2], 32'h41);
        wait_until(e0 + 3 * PER + 5);
        bus.repeat_mode = 1'b0;
        chk("t3_dones", done_cnt - dc0, 32'd1);
        chk("t3_busy", bus.busy, 32'd0);

        // 4a: zero length is ignored
        dc0 = done_cnt;
        go(0, 1'b0, 0, 1'b0, e0);
        repeat (20) tick();
        chk("t4_zero_busy", bus.busy, 32'd0);
        chk("t4_zero_tx", bus.tx, 32'd1);
        chk("t4_zero_done", done_cnt - dc0, 32'd0);

        // 4b: length 40 clamps to 32
        for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 5 + 7));
        dc0 = done_cnt;
        go(40, 1'b0, 32, 1'b0, e0);
        wait_until(e0 + 32 * PER + 2);
        chk("t4_last_idx", bus.char_index, 32'd31);
        chk("t4_busy", bus.busy, 32'd0);
        chk("t4_dones", done_cnt - dc0, 32'd1);

        // 5: reset during data bit 4 of 0x4A (bit 4 is 0)
        wr(0, 8'h4A);
        go(1, 1'b0, 1, 1'b0, e0);
        wait_until(e0 + 3 + 10 * 5 + 4);
        chk("t5_pre_tx", bus.tx, 32'd0);
        fill_idle(cyc, '0);
        reset = 1'b0;
        #1;
        chk("t5_async_tx", bus.tx, 32'd1);
        chk("t5_async_busy", bus.busy, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        go(1, 1'b0, 1, 1'b0, e0);
        rx_frame(rd[0], b9[0], fl[0]);
        chk("t5_resend", rd[0], 32'h4A);
        wait_until(e0 + PER + 2);

`ifdef TX_PARITY_EN
        // 6: parity, even then odd
        wr(0, 8'h41);
        po_m = 1'b0; bus.parity_odd = 1'b0;
        go(1, 1'b0, 1, 1'b0, e0);
        rx_frame(rd[0], b9[0], fl[0]);
        chk("t6_even", b9[0], 32'd0);
        wait_until(e0 + 112);
        chk("t6_busy_in", bus.busy, 32'd1);
        tick();
        chk("t6_busy_out", bus.busy, 32'd0);
        po_m = 1'b1; bus.parity_odd = 1'b1;
        go(1, 1'b0, 1, 1'b0, e0);
        rx_frame(rd[0], b9[0], fl[0]);
        chk("t6_odd", b9[0], 32'd1);
        wait_until(e0 + PER + 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_string_transmitter.md
Name: ram_string_transmitter

Overview:
Parametrised successor to the fixed RAM-to-terminal transmitter. It holds a writable message RAM and, on command, streams `msg_length` characters out of a serial line as asynchronous UART frames. Character width, stop bits, baud rate, depth and a repeat mode are all configurable. The block contains its own bit-period divider, frame shifter and sequencing controller, and sits between system control logic and the board's UART TX pin.

Parameters:
- CLK_FREQ, 40000000, input clock frequency in Hz.
- BAUD_RATE, 19200, line rate. BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer, truncated). Must be ≥4.
- DATA_BITS, 8, character width, legal range 5..8.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- ADDR_BITS, 5, RAM address width.
- DEPTH, 32, RAM entries. Must satisfy DEPTH ≤ 2^ADDR_BITS.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: RAM write strobe.
- wr_addr, input, ADDR_BITS: RAM write address.
- wr_data, input, DATA_BITS: RAM write data.
- start, input, 1: begin a message. Sampled only in IDLE.
- abort, input, 1: stop after the current frame completes.
- repeat_mode, input, 1: at end of message, wrap to address 0 and continue.
- msg_length, input, ADDR_BITS+1: number of characters to send.
- tx, output, 1: serial line. Idles high.
- busy, output, 1: high whenever the block is not in IDLE.
- done, output, 1: one-cycle pulse at the end of each message pass.
- char_index, output, ADDR_BITS: address of the character currently being sent.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - Outputs go immediately to tx=1, busy=0, done=0, char_index=0.
  - FSM goes to IDLE; bit and cycle counters clear.
  - RAM contents are not cleared.
  - Reset asserted mid-frame truncates the frame at once; tx returns high.
- **RAM:**
  - DEPTH×DATA_BITS, synchronous write and synchronous read.
  - Writes are accepted in any state.
  - Same-cycle write and read at one address returns the old data (read-first).
  - Writes with wr_addr ≥ DEPTH are ignored.
- **Length:** effective length L = min(msg_length, DEPTH).
- **FSM states:** IDLE, FETCH, LOAD, START, DATA, STOP, GAP.
- **IDLE:**
  - start=1 with L≠0 → FETCH, with char_index=0.
  - start=1 with L=0 is ignored: no busy, no done.
- **FETCH:** presents the RAM address (1 cycle).
- **LOAD:** latches the RAM data into the shift register (1 cycle).
- **Start-bit latency:** tx falls on the 3rd rising edge after the edge that sampled start.
- **START:** tx=0 for BIT_CYCLES clocks.
- **DATA:** DATA_BITS bits, LSB first, each held for BIT_CYCLES clocks.
- **STOP:** tx=1 for STOP_BITS×BIT_CYCLES clocks.
- **Cycle counter:** reloads at every bit boundary, so bit timing has no cumulative drift.
- **GAP:** tx=1; decision point after each frame.
  - abort was seen since the frame began → IDLE. No done; abort is latched.
  - char_index < L−1 → increment char_index → FETCH.
  - char_index = L−1 → done=1 for 1 cycle, then:
    - repeat_mode=1 → char_index=0 → FETCH.
    - otherwise → IDLE.
- **Inter-character spacing:** minimum 3 idle-high cycles (GAP, FETCH, LOAD) beyond the stop bits.
- **start while busy:** ignored.
- **msg_length / repeat_mode changes while busy:** take effect at the next GAP decision.
- **Last-character abort:** abort during the last character suppresses done.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined: a parity bit is inserted between the last data bit and the stop bits, lasting BIT_CYCLES clocks.
  - Parity sense is set by a new input port `parity_odd`: 0 = even, 1 = odd.
  - `parity_odd` is sampled in LOAD.
  - Frame length becomes (2+DATA_BITS+STOP_BITS)×BIT_CYCLES.
- Undefined: no parity bit and no `parity_odd` port. Frame is (1+DATA_BITS+STOP_BITS)×BIT_CYCLES.

Test Plan:
Bench parameters: CLK_FREQ=1000000, BAUD_RATE=100000 (BIT_CYCLES=10), DATA_BITS=8, STOP_BITS=1.

1. **Single character.** Write 0x41 to address 0; msg_length=1; pulse start.
   - tx falls 3 edges after start, then sends 0,1,0,0,0,0,0,1,0,1, each bit 10 cycles.
   - done pulses once; busy drops; char_index=0.
2. **Three-character message.** Write "HI!" to addresses 0..2; msg_length=3.
   - Three frames decode to 0x48, 0x49, 0x21.
   - Exactly 3 idle-high cycles between stop bit and next start bit.
   - Single done after the third frame.
3. **Repeat and abort.** repeat_mode=1, msg_length=2 ("AB"); run.
   - Decoded stream is ABAB…; done pulses every 2 frames.
   - Assert abort mid second 'A' → that frame completes; IDLE; no further done.
4. **Boundary lengths.**
   - msg_length=0 → busy stays 0, tx stays 1.
   - msg_length=40 with DEPTH=32 → exactly 32 frames, last from address 31, then done.
5. **Reset mid-frame.** Assert reset during data bit 4.
   - tx=1 and busy=0 immediately, without waiting for a clock.
   - After release, restarting resends address 0 correctly; RAM contents preserved.
6. **Parity** (with TX_PARITY_EN). Send 0x41 with parity_odd=0.
   - Parity bit = 0; frame is 110 cycles.
   - With parity_odd=1, parity bit = 1.
